// File: rtl/io_core_buffered.sv
// Buffered IO probe core on the daisy-chained register bus: atomic input snapshots,
// double-buffered outputs with atomic commit, sticky change flags, 1-cycle bus pass-through.
module io_core_buffered #(
  parameter int                   BASE_ADDR = 0,
  parameter int                   N_IN      = 4,
  parameter int                   IN_WIDTH  = 8,
  parameter int                   N_OUT     = 4,
  parameter int                   OUT_WIDTH = 8,
  parameter logic [OUT_WIDTH-1:0] OUT_INIT  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN*IN_WIDTH-1:0]   probe_in,
  output logic [N_OUT*OUT_WIDTH-1:0] probe_out,
  input  logic [15:0]                addr_i,
  input  logic [15:0]                wdata_i,
  input  logic [15:0]                rdata_i,
  input  logic                       rw_i,
  input  logic                       valid_i,
  output logic [15:0]                addr_o,
  output logic [15:0]                wdata_o,
  output logic [15:0]                rdata_o,
  output logic                       rw_o,
  output logic                       valid_o
);

  localparam int LAST_OFF = 1 + N_IN + N_OUT;
  localparam int OUT_OFF  = 2 + N_IN;

  logic [N_IN-1:0][IN_WIDTH-1:0]   probe_q;
  logic [N_IN-1:0][IN_WIDTH-1:0]   snap;
  logic [N_OUT-1:0][OUT_WIDTH-1:0] stage;
  logic [N_IN-1:0]                 change;
  logic [N_IN-1:0]                 change_set;
  logic [N_IN-1:0]                 change_clr;
  logic [N_IN-1:0]                 change_nxt;

  logic [16:0] diff;
  logic [15:0] off;
  logic        in_range;
  logic        rd_hit;
  logic        wr_hit;
  logic        do_snap;
  logic        do_commit;
  logic [15:0] rd_val;

  // Borrow out of the subtraction marks addresses below BASE_ADDR.
  assign diff      = {1'b0, addr_i} - 17'(BASE_ADDR);
  assign off       = diff[15:0];
  assign in_range  = !diff[16] && (off <= 16'(LAST_OFF));
  assign rd_hit    = valid_i && !rw_i && in_range;
  assign wr_hit    = valid_i && rw_i && in_range;
  assign do_snap   = wr_hit && (off == 16'd0) && wdata_i[0];
  assign do_commit = wr_hit && (off == 16'd0) && wdata_i[1];

  always_comb begin
    change_set = '0;
    for (int i = 0; i < N_IN; i++) begin
      change_set[i] = (probe_q[i] != probe_in[i*IN_WIDTH +: IN_WIDTH]);
    end
  end

  // A fresh change wins over a same-cycle write-1-to-clear.
  assign change_clr = (wr_hit && (off == 16'd1)) ? wdata_i[N_IN-1:0] : '0;
  assign change_nxt = (change & ~change_clr) | change_set;

  always_comb begin
    rd_val = '0;
    if (off == 16'd1) begin
      rd_val = 16'(change);
    end
    for (int i = 0; i < N_IN; i++) begin
      if (off == 16'(2 + i)) begin
        rd_val = 16'(snap[i]);
      end
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (off == 16'(OUT_OFF + j)) begin
        rd_val = 16'(stage[j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_o    <= '0;
      wdata_o   <= '0;
      rdata_o   <= '0;
      rw_o      <= 1'b0;
      valid_o   <= 1'b0;
      probe_q   <= '0;
      snap      <= '0;
      change    <= '0;
      stage     <= {N_OUT{OUT_INIT}};
      probe_out <= {N_OUT{OUT_INIT}};
    end else begin
      addr_o  <= addr_i;
      wdata_o <= wdata_i;
      rw_o    <= rw_i;
      valid_o <= valid_i;
      rdata_o <= rd_hit ? rd_val : rdata_i;
      probe_q <= probe_in;
      change  <= change_nxt;
      if (do_snap) begin
        snap <= probe_q;
      end
      if (do_commit) begin
        probe_out <= stage;
      end
      for (int j = 0; j < N_OUT; j++) begin
        if (wr_hit && (off == 16'(OUT_OFF + j))) begin
          stage[j] <= wdata_i[OUT_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_io_core_buffered.sv
// Bench for io_core_buffered: directed scenarios plus random bus/probe traffic,
// every cycle compared against a register-map level reference model.
module tb_io_core_buffered;

  localparam int BASE   = 0;
  localparam int NCH_IN = 4;
  localparam int NCH_OUT = 4;
  localparam int MAXA   = BASE + 1 + NCH_IN + NCH_OUT;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] probe_in;
  logic [31:0] probe_out;
  logic [15:0] addr_i, wdata_i, rdata_i, addr_o, wdata_o, rdata_o;
  logic        rw_i, valid_i, rw_o, valid_o;

  int checks = 0;
  int failures = 0;

  io_core_buffered #(
    .BASE_ADDR(BASE), .N_IN(NCH_IN), .IN_WIDTH(8),
    .N_OUT(NCH_OUT), .OUT_WIDTH(8), .OUT_INIT(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .probe_in(probe_in), .probe_out(probe_out),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0] m_pq[NCH_IN], m_snap[NCH_IN], m_stage[NCH_OUT], m_pout[NCH_OUT];
  logic [3:0] m_change;
  logic [15:0] e_addr, e_wdata, e_rdata;
  logic        e_rw, e_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    int off;
    logic [15:0] rv;
    logic [7:0] pin[NCH_IN];
    logic [3:0] nchg;
    for (int i = 0; i < NCH_IN; i++) pin[i] = probe_in[i*8 +: 8];
    if (rst) begin
      e_addr = 0; e_wdata = 0; e_rdata = 0; e_rw = 0; e_valid = 0;
      m_change = 0;
      for (int i = 0; i < NCH_IN; i++) begin m_pq[i] = 0; m_snap[i] = 0; end
      for (int j = 0; j < NCH_OUT; j++) begin m_stage[j] = 8'h00; m_pout[j] = 8'h00; end
      return;
    end
    off = int'(addr_i) - BASE;
    rv = 0;
    if (off == 1) rv = 16'(m_change);
    else if (off >= 2 && off < 2 + NCH_IN) rv = {8'h00, m_snap[off-2]};
    else if (off >= 2 + NCH_IN && off <= MAXA - BASE) rv = {8'h00, m_stage[off-2-NCH_IN]};
    e_addr = addr_i; e_wdata = wdata_i; e_rw = rw_i; e_valid = valid_i;
    e_rdata = (valid_i && !rw_i && off >= 0 && off <= MAXA - BASE) ? rv : rdata_i;
    for (int i = 0; i < NCH_IN; i++) begin
      if (m_pq[i] != pin[i]) nchg[i] = 1'b1;
      else if (valid_i && rw_i && off == 1 && wdata_i[i]) nchg[i] = 1'b0;
      else nchg[i] = m_change[i];
    end
    m_change = nchg;
    if (valid_i && rw_i) begin
      if (off == 0) begin
        if (wdata_i[1]) for (int j = 0; j < NCH_OUT; j++) m_pout[j] = m_stage[j];
        if (wdata_i[0]) for (int i = 0; i < NCH_IN; i++) m_snap[i] = m_pq[i];
      end else if (off >= 2 + NCH_IN && off <= MAXA - BASE) begin
        m_stage[off-2-NCH_IN] = wdata_i[7:0];
      end
    end
    for (int i = 0; i < NCH_IN; i++) m_pq[i] = pin[i];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("addr_o", addr_o, e_addr);
    chk("wdata_o", wdata_o, e_wdata);
    chk("rw_o", rw_o, e_rw);
    chk("valid_o", valid_o, e_valid);
    chk("rdata_o", rdata_o, e_rdata);
    for (int j = 0; j < NCH_OUT; j++) chk("probe_out", probe_out[j*8 +: 8], m_pout[j]);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    addr_i = a; wdata_i = d; rw_i = 1'b1; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] r);
    addr_i = a; rw_i = 1'b0; valid_i = 1'b1; rdata_i = 16'h0000;
    tick();
    r = rdata_o;
    valid_i = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    rst = 1'b1; probe_in = 32'h0; addr_i = 0; wdata_i = 0; rdata_i = 0; rw_i = 0; valid_i = 0;
    tick(); tick();
    rst = 1'b0;

    // 1: reset contents of every register
    for (int a = BASE; a <= MAXA; a++) begin
      bus_rd(16'(a), r);
      chk("t1_reset_read", r, 0);
      chk("t1_valid_o", valid_o, 1);
    end
    tick();
    chk("t1_valid_drop", valid_o, 0);

    // 2: snapshot is frozen until the next strobe
    probe_in[2*8 +: 8] = 8'hA5;
    tick();
    bus_wr(BASE + 0, 16'h0001);
    bus_rd(BASE + 4, r);
    chk("t2_snap", r, 16'h00A5);
    probe_in[2*8 +: 8] = 8'h3C;
    tick(); tick();
    bus_rd(BASE + 4, r);
    chk("t2_snap_hold", r, 16'h00A5);

    // 3: staging truncation and commit
    bus_wr(BASE + 2 + NCH_IN, 16'h01FF);
    chk("t3_no_move", probe_out[7:0], 8'h00);
    bus_wr(BASE + 0, 16'h0002);
    chk("t3_commit", probe_out[7:0], 8'hFF);

    // 4: change flags, set wins over clear
    bus_wr(BASE + 1, 16'h000F);
    bus_rd(BASE + 1, r);
    chk("t4_cleared", r, 16'h0000);
    probe_in[1*8 +: 8] = ~probe_in[1*8 +: 8];
    tick();
    bus_rd(BASE + 1, r);
    chk("t4_change", r, 16'h0002);
    probe_in[1*8 +: 8] = ~probe_in[1*8 +: 8];
    bus_wr(BASE + 1, 16'h0002);
    bus_rd(BASE + 1, r);
    chk("t4_set_wins", r, 16'h0002);

    // 5: out-of-range pass-through
    addr_i = 16'(MAXA + 1); wdata_i = 16'h1234; rw_i = 1'b0; valid_i = 1'b1; rdata_i = 16'hBEEF;
    tick();
    chk("t5_rdata", rdata_o, 16'hBEEF);
    chk("t5_addr", addr_o, 16'(MAXA + 1));
    chk("t5_wdata", wdata_o, 16'h1234);
    valid_i = 1'b0;

    // 6: reset aborts an in-flight staging write
    bus_wr(BASE + 5 + NCH_IN, 16'h0055);
    addr_i = 16'(BASE + 5 + NCH_IN); wdata_i = 16'h00AA; rw_i = 1'b1; valid_i = 1'b1; rst = 1'b1;
    tick();
    chk("t6_valid_o", valid_o, 0);
    rst = 1'b0; valid_i = 1'b0;
    tick();
    chk("t6_valid_o_next", valid_o, 0);
    bus_rd(BASE + 5 + NCH_IN, r);
    chk("t6_stage3", r, 16'h0000);

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) probe_in[$urandom_range(0, NCH_IN-1)*8 +: 8] = 8'($urandom);
      addr_i  = 16'(BASE + $urandom_range(0, MAXA - BASE + 3));
      wdata_i = 16'($urandom);
      rdata_i = 16'($urandom);
      rw_i    = 1'($urandom);
      valid_i = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0; valid_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
